// File: rtl/mul4_pkg.sv
// mul4_pkg: shared definitions for the 2x2 vector-multiplier fitness scorer.
//   LANES    - bit-parallel lanes per beat (one lane per bit position)
//   OUT_BITS - product bits per lane
//   state_t  - scorer FSM states
//   golden_mul2() - reference 2x2 product for all lanes, element [k] = product bit k
package mul4_pkg;

    localparam int LANES    = 16;
    localparam int OUT_BITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [OUT_BITS-1:0][LANES-1:0] prod_t;

    function automatic prod_t golden_mul2(
        input logic [LANES-1:0] a1,
        input logic [LANES-1:0] a0,
        input logic [LANES-1:0] b1,
        input logic [LANES-1:0] b0
    );
        prod_t            p;
        logic [LANES-1:0] c;
        // Carry out of the middle column feeds both upper product bits.
        c    = a1 & b0 & a0 & b1;
        p[0] = a0 & b0;
        p[1] = (a1 & b0) ^ (a0 & b1);
        p[2] = (a1 & b1) ^ c;
        p[3] = a1 & b1 & c;
        return p;
    endfunction

endpackage

// File: rtl/mul4_popcount64.sv
// mul4_popcount64: combinational population count of a 64-bit vector.
//   vec - input bits
//   cnt - number of set bits, 0..64
module mul4_popcount64 (
    input  logic [63:0] vec,
    output logic [6:0]  cnt
);

    always_comb begin
        cnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(vec[i]);
        end
    end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// mul4_fitness_scorer: scores one evolved 2x2 vector-multiplier candidate.
// Each accepted beat compares the candidate outputs y3..y0 against the golden
// product of a1,a0 x b1,b0 across 16 lanes and adds the number of matching
// bits (0..64) to an accumulator; after BEATS beats the total is presented.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - begin evaluation (sampled only in IDLE)
//   in_valid / in_ready - beat handshake
//   a1,a0,b1,b0         - operand bits, one lane per bit position
//   y3..y0              - candidate product bits
//   score_valid / score_ready - result handshake
//   score, perfect      - correct-bit total, and total == 64*BEATS
//   busy                - FSM not in IDLE
module mul4_fitness_scorer
    import mul4_pkg::*;
#(
    parameter int BEATS   = 4,
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES-1:0]   a1,
    input  logic [LANES-1:0]   a0,
    input  logic [LANES-1:0]   b1,
    input  logic [LANES-1:0]   b0,
    input  logic [LANES-1:0]   y3,
    input  logic [LANES-1:0]   y2,
    input  logic [LANES-1:0]   y1,
    input  logic [LANES-1:0]   y0,
    output logic               score_valid,
    input  logic               score_ready,
    output logic [SCORE_W-1:0] score,
    output logic               perfect,
    output logic               busy
);

    localparam int                 CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int                 MASK_W = LANES * OUT_BITS;
    localparam logic [SCORE_W-1:0] FULL  = SCORE_W'(MASK_W * BEATS);

    generate
        if (BEATS < 1) begin : g_bad_beats
            $error("mul4_fitness_scorer: BEATS must be at least 1");
        end
        if (SCORE_W < 32 && (64 * BEATS) >= (1 << SCORE_W)) begin : g_bad_width
            $error("mul4_fitness_scorer: SCORE_W too narrow for 64*BEATS");
        end
    endgenerate

    function automatic logic [SCORE_W-1:0] correct_bits(input logic [6:0] mism);
        return SCORE_W'(7'd64 - mism);
    endfunction

    state_t              state;
    logic [CNT_W-1:0]    beat_cnt;
    logic [SCORE_W-1:0]  acc;
    logic                accept;
    logic                last_beat;
    prod_t               gold;
    logic [MASK_W-1:0]   mask;
    logic [MASK_W-1:0]   mask_p1;
    logic                vld_p1;
    logic                vld_p2;
    logic [6:0]          mism_p1;

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (beat_cnt == CNT_W'(BEATS - 1));
    assign gold      = golden_mul2(a1, a0, b1, b0);
    assign mask      = {y3 ^ gold[3], y2 ^ gold[2], y1 ^ gold[1], y0 ^ gold[0]};
    assign score     = acc;

    // ---- stage p1: registered mismatch mask ----
    always_ff @(posedge clk) begin
        if (accept) begin
            mask_p1 <= mask;
        end
    end

    // ---- stage p2: popcount of p1 mask, folded into the accumulator ----
    mul4_popcount64 u_popcount (
        .vec (mask_p1),
        .cnt (mism_p1)
    );

    // FSM, pipe valids and accumulator. Later assignments in the case
    // statement deliberately override the default pipeline updates when an
    // evaluation starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            score_valid <= 1'b0;
            perfect     <= 1'b0;
            beat_cnt    <= '0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            acc         <= '0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                acc <= acc + correct_bits(mism_p1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        perfect  <= 1'b0;
                        beat_cnt <= '0;
                        vld_p1   <= 1'b0;
                        vld_p2   <= 1'b0;
                        acc      <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    if (last_beat) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    // vld_p2 marks the cycle after the final add, so both
                    // being clear means acc already holds the full total.
                    if (!vld_p1 && !vld_p2) begin
                        state       <= DONE;
                        score_valid <= 1'b1;
                        perfect     <= (acc == FULL);
                    end
                end
                DONE: begin
                    if (score_ready) begin
                        state       <= IDLE;
                        score_valid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul4_fitness_scorer.md
# mul4_fitness_scorer

Scores one evolved 2-bit × 2-bit vector-multiplier candidate. Each accepted beat carries 16-lane bit-parallel stimulus (`a1,a0,b1,b0`) plus the candidate's outputs (`y3..y0`). The block computes the golden product per lane, counts matching output bits, and accumulates over `BEATS` beats. It sits directly downstream of the candidate circuit under evaluation and hands a single fitness score to the tournament selector.

## Interface
- `BEATS`, default 4: beats per evaluation, ≥1.
- `SCORE_W`, default 16: score width.
  - Elaboration check: `64*BEATS < 2**SCORE_W`.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: begin evaluation; sampled only in IDLE.
- `in_valid` input 1: beat present.
- `in_ready` output 1: beat accepted when `in_valid && in_ready`.
- `a1, a0, b1, b0` input 16 each: operand bits, one lane per bit position.
- `y3, y2, y1, y0` input 16 each: candidate product bits.
- `score_valid` output 1: score available.
- `score_ready` input 1: consumer takes score.
- `score` output SCORE_W: count of correct output bits over all beats.
- `perfect` output 1: `score == 64*BEATS`; valid with `score_valid`.
- `busy` output 1: state ≠ IDLE.

## Operation
- Golden product per lane, with A={a1,a0} and B={b1,b0}:
  - `p0=a0&b0`
  - `p1=(a1&b0)^(a0&b1)`
  - `c=a1&b0&a0&b1`
  - `p2=(a1&b1)^c`
  - `p3=a1&b1&c`
- Mismatch mask (64 bits) = `{y3^p3, y2^p2, y1^p1, y0^p0}`.
- Correct bits per beat = 64 − popcount(mask), range 0..64.
- Two-stage datapath:
  - S1: register mismatch mask plus valid.
  - S2: popcount, then add to accumulator.
- FSM states:
  - IDLE: `start` → ACCUM. The accumulator, beat counter and pipe valids clear on entry to ACCUM.
  - ACCUM: `in_ready=1`. Each handshake increments `beat_cnt`. Handshake on beat `BEATS-1` → DRAIN.
  - DRAIN: `in_ready=0`. Wait until S1 and S2 are empty (2 cycles), then → DONE.
  - DONE: `score_valid=1`. `score` and `perfect` are held stable. `score_ready` → IDLE.
- `start` in any state other than IDLE is ignored.
- Beats with `in_valid` asserted outside ACCUM are not accepted and are not scored.
- Accumulator is SCORE_W wide and never wraps (guaranteed by the elaboration check).

## Timing
- Reset values: state=IDLE, `in_ready=0`, `score_valid=0`, `score=0`, `perfect=0`, `busy=0`, pipe valids=0.
- `in_ready` is asserted the cycle after `start` is sampled in IDLE.
- Latency: last beat accepted at edge T → `score_valid` high after edge T+3.
- Throughput: one beat per cycle in ACCUM; gaps in `in_valid` are allowed.
- `score_valid` stays high with stable outputs until `score_ready`.
- On the `score_ready` edge the state is IDLE. `score_valid` drops next cycle. `score` retains its value until the next ACCUM entry.
- Idle cycle rule: `start` asserted in the same cycle as the `score_ready` handshake is not seen. A new evaluation needs `start` in IDLE.
- `rst_n` low at any time, including mid-ACCUM or DONE, immediately forces every reset value. Partial scores are discarded.

## Structure
- Package `mul4_pkg` holds:
  - `LANES=16`, `OUT_BITS=4`
  - state enum (IDLE, ACCUM, DRAIN, DONE)
  - function `golden_mul2(a1,a0,b1,b0)` returning four 16-bit vectors
- Sub-module `mul4_popcount64`: combinational 64-bit popcount to 7 bits, instantiated in S2.

## Test plan
- Exhaustive stimulus is used in every test: `a1=16'hFF00`, `a0=16'hF0F0`, `b1=16'hCCCC`, `b0=16'hAAAA`.
1. Candidate = golden product for 4 beats → `score=256`, `perfect=1`, `score_valid` 3 cycles after the last beat.
2. Candidate all-zero `y` for 4 beats → `score=200` (50 per beat; golden has 14 one-bits), `perfect=0`.
3. Candidate all-ones `y` for 4 beats → `score=56`, `perfect=0`.
4. Golden beats with random `in_valid` gaps, plus `score_ready` held low for 5 cycles → `score=256` stable throughout, `in_ready=0`, then IDLE one cycle after `score_ready`.
5. `rst_n` pulsed low after 2 of 4 beats → all outputs 0 immediately. A new `start` with 4 golden beats → `score=256`, with no carry-over.
6. `start` pulsed during ACCUM and during DONE → ignored. Extra `in_valid` during DRAIN is not accepted and the score is unchanged.
